// File: rtl/equeue_int_pkg.sv
// Shared definitions for the integer issue queue.
//   - Default operand/tag/opcode widths and queue depth.
//   - TAG_NULL: the tag carried on the CDB by ops with no destination
//     (stores); it never wakes up a waiting operand.
//   - slot_src_e: where a queue slot takes its next contents from.
package equeue_int_pkg;

  localparam int DEPTH_DEF  = 4;
  localparam int TAG_W_DEF  = 6;
  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 6;

  localparam int TAG_NULL   = 0;

  typedef enum logic [1:0] {
    SRC_HOLD  = 2'd0,  // keep own contents
    SRC_SHIFT = 2'd1,  // take contents of slot i+1 (compaction after issue)
    SRC_DISP  = 2'd2,  // take the dispatched op
    SRC_CLEAR = 2'd3   // slot becomes empty
  } slot_src_e;

endpackage

// File: rtl/equeue_int_entry.sv
// One slot of the integer issue queue.
// Holds an op and its two source operands, snoops the CDB to capture
// missing operands, and loads from its own state, the slot above it, or
// the dispatch port as chosen by the top level. The CDB capture is applied
// to whichever contents are being loaded, so an entry that shifts or is
// dispatched in the same cycle as a matching broadcast still captures it.
// Ports:
//   clk, i_rst_n         clock, async active-low reset (clears valid only)
//   i_src                next-contents source select
//   i_cdb_*              CDB broadcast
//   i_up_*               contents of slot i+1
//   i_disp_*             dispatched op
//   o_*                  registered contents, o_ready = valid & both operands
module equeue_int_entry
  import equeue_int_pkg::*;
#(
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  slot_src_e         i_src,
  input  logic              i_cdb_valid,
  input  logic [TAG_W-1:0]  i_cdb_tag,
  input  logic [DATA_W-1:0] i_cdb_data,
  input  logic              i_up_valid,
  input  logic [OP_W-1:0]   i_up_opcode,
  input  logic [DATA_W-1:0] i_up_rsdata,
  input  logic [TAG_W-1:0]  i_up_rstag,
  input  logic              i_up_rsvalid,
  input  logic [DATA_W-1:0] i_up_rtdata,
  input  logic [TAG_W-1:0]  i_up_rttag,
  input  logic              i_up_rtvalid,
  input  logic [TAG_W-1:0]  i_up_rdtag,
  input  logic [OP_W-1:0]   i_disp_opcode,
  input  logic [DATA_W-1:0] i_disp_rsdata,
  input  logic [TAG_W-1:0]  i_disp_rstag,
  input  logic              i_disp_rsvalid,
  input  logic [DATA_W-1:0] i_disp_rtdata,
  input  logic [TAG_W-1:0]  i_disp_rttag,
  input  logic              i_disp_rtvalid,
  input  logic [TAG_W-1:0]  i_disp_rdtag,
  output logic              o_valid,
  output logic [OP_W-1:0]   o_opcode,
  output logic [DATA_W-1:0] o_rsdata,
  output logic [TAG_W-1:0]  o_rstag,
  output logic              o_rsvalid,
  output logic [DATA_W-1:0] o_rtdata,
  output logic [TAG_W-1:0]  o_rttag,
  output logic              o_rtvalid,
  output logic [TAG_W-1:0]  o_rdtag,
  output logic              o_ready
);

  logic              r_valid;
  logic [OP_W-1:0]   r_opcode;
  logic [DATA_W-1:0] r_rsdata;
  logic [TAG_W-1:0]  r_rstag;
  logic              r_rsvalid;
  logic [DATA_W-1:0] r_rtdata;
  logic [TAG_W-1:0]  r_rttag;
  logic              r_rtvalid;
  logic [TAG_W-1:0]  r_rdtag;

  // Candidate contents before CDB capture
  logic              w_valid;
  logic [OP_W-1:0]   w_opcode;
  logic [DATA_W-1:0] w_rsdata;
  logic [TAG_W-1:0]  w_rstag;
  logic              w_rsvalid;
  logic [DATA_W-1:0] w_rtdata;
  logic [TAG_W-1:0]  w_rttag;
  logic              w_rtvalid;
  logic [TAG_W-1:0]  w_rdtag;

  logic w_cdb_live;
  logic w_rs_hit;
  logic w_rt_hit;

  always_comb begin
    w_valid   = r_valid;
    w_opcode  = r_opcode;
    w_rsdata  = r_rsdata;
    w_rstag   = r_rstag;
    w_rsvalid = r_rsvalid;
    w_rtdata  = r_rtdata;
    w_rttag   = r_rttag;
    w_rtvalid = r_rtvalid;
    w_rdtag   = r_rdtag;
    case (i_src)
      SRC_SHIFT: begin
        w_valid   = i_up_valid;
        w_opcode  = i_up_opcode;
        w_rsdata  = i_up_rsdata;
        w_rstag   = i_up_rstag;
        w_rsvalid = i_up_rsvalid;
        w_rtdata  = i_up_rtdata;
        w_rttag   = i_up_rttag;
        w_rtvalid = i_up_rtvalid;
        w_rdtag   = i_up_rdtag;
      end
      SRC_DISP: begin
        w_valid   = 1'b1;
        w_opcode  = i_disp_opcode;
        w_rsdata  = i_disp_rsdata;
        w_rstag   = i_disp_rstag;
        w_rsvalid = i_disp_rsvalid;
        w_rtdata  = i_disp_rtdata;
        w_rttag   = i_disp_rttag;
        w_rtvalid = i_disp_rtvalid;
        w_rdtag   = i_disp_rdtag;
      end
      SRC_CLEAR: w_valid = 1'b0;
      default:   w_valid = r_valid;
    endcase
  end

  // Tag 0 is broadcast by stores and must never wake anything up.
  assign w_cdb_live = i_cdb_valid && (i_cdb_tag != TAG_W'(TAG_NULL));
  assign w_rs_hit   = w_cdb_live && w_valid && !w_rsvalid && (w_rstag == i_cdb_tag);
  assign w_rt_hit   = w_cdb_live && w_valid && !w_rtvalid && (w_rttag == i_cdb_tag);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) r_valid <= 1'b0;
    else          r_valid <= w_valid;
  end

  // Payload is only meaningful while r_valid is set, so it carries no reset.
  always_ff @(posedge clk) begin
    r_opcode  <= w_opcode;
    r_rsdata  <= w_rs_hit ? i_cdb_data : w_rsdata;
    r_rstag   <= w_rstag;
    r_rsvalid <= w_rsvalid | w_rs_hit;
    r_rtdata  <= w_rt_hit ? i_cdb_data : w_rtdata;
    r_rttag   <= w_rttag;
    r_rtvalid <= w_rtvalid | w_rt_hit;
    r_rdtag   <= w_rdtag;
  end

  assign o_valid   = r_valid;
  assign o_opcode  = r_opcode;
  assign o_rsdata  = r_rsdata;
  assign o_rstag   = r_rstag;
  assign o_rsvalid = r_rsvalid;
  assign o_rtdata  = r_rtdata;
  assign o_rttag   = r_rttag;
  assign o_rtvalid = r_rtvalid;
  assign o_rdtag   = r_rdtag;
  assign o_ready   = r_valid & r_rsvalid & r_rtvalid;

endmodule

// File: rtl/equeue_int.sv
// Integer issue queue.
// Accepts dispatched integer ops whose operands may still be in flight,
// captures missing operands from the CDB, and presents the oldest ready
// op to the issue unit. Entries are kept oldest-first in slots
// 0..count-1; an issued entry is removed and everything above it shifts
// down one slot in the same edge.
// Ports:
//   clk, reset              clock, async active-low reset
//   dispatch_*              op write port (ignored while equeue_full)
//   equeue_full             all DEPTH slots occupied
//   cdb_valid/tag/data      result broadcast
//   issueint_*              oldest ready entry (all zero when none ready)
//   issueint_equeueint_done issue unit took the presented entry
module equeue_int
  import equeue_int_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dispatch_en,
  input  logic [OP_W-1:0]   dispatch_opcode,
  input  logic [DATA_W-1:0] dispatch_rsdata,
  input  logic [TAG_W-1:0]  dispatch_rstag,
  input  logic              dispatch_rsvalid,
  input  logic [DATA_W-1:0] dispatch_rtdata,
  input  logic [TAG_W-1:0]  dispatch_rttag,
  input  logic              dispatch_rtvalid,
  input  logic [TAG_W-1:0]  dispatch_rdtag,
  output logic              equeue_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              issueint_ready,
  output logic [OP_W-1:0]   issueint_opcode,
  output logic [DATA_W-1:0] issueint_rsdata,
  output logic [DATA_W-1:0] issueint_rtdata,
  output logic [TAG_W-1:0]  issueint_rdtag,
  input  logic              issueint_equeueint_done
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] r_count;

  // Slot views; element DEPTH is an always-empty slot feeding the top entry.
  logic              w_valid   [DEPTH+1];
  logic [OP_W-1:0]   w_opcode  [DEPTH+1];
  logic [DATA_W-1:0] w_rsdata  [DEPTH+1];
  logic [TAG_W-1:0]  w_rstag   [DEPTH+1];
  logic              w_rsvalid [DEPTH+1];
  logic [DATA_W-1:0] w_rtdata  [DEPTH+1];
  logic [TAG_W-1:0]  w_rttag   [DEPTH+1];
  logic              w_rtvalid [DEPTH+1];
  logic [TAG_W-1:0]  w_rdtag   [DEPTH+1];
  logic              w_ready   [DEPTH];
  slot_src_e         w_src     [DEPTH];

  logic             w_any;
  logic [CNT_W-1:0] w_sel;
  logic             w_issue;
  logic             w_disp;
  logic [CNT_W-1:0] w_wslot;

  assign w_valid[DEPTH]   = 1'b0;
  assign w_opcode[DEPTH]  = '0;
  assign w_rsdata[DEPTH]  = '0;
  assign w_rstag[DEPTH]   = '0;
  assign w_rsvalid[DEPTH] = 1'b0;
  assign w_rtdata[DEPTH]  = '0;
  assign w_rttag[DEPTH]   = '0;
  assign w_rtvalid[DEPTH] = 1'b0;
  assign w_rdtag[DEPTH]   = '0;

  assign equeue_full = (r_count == CNT_W'(DEPTH));
  assign w_disp      = dispatch_en && !equeue_full;
  assign w_issue     = w_any && issueint_equeueint_done;
  // After a removal the queue tail has moved down by one.
  assign w_wslot     = r_count - CNT_W'(w_issue);

  // Lowest-index ready entry wins: scan from the top so the last hit sticks.
  always_comb begin
    w_any           = 1'b0;
    w_sel           = '0;
    issueint_opcode = '0;
    issueint_rsdata = '0;
    issueint_rtdata = '0;
    issueint_rdtag  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_any           = 1'b1;
        w_sel           = CNT_W'(i);
        issueint_opcode = w_opcode[i];
        issueint_rsdata = w_rsdata[i];
        issueint_rtdata = w_rtdata[i];
        issueint_rdtag  = w_rdtag[i];
      end
    end
  end

  assign issueint_ready = w_any;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_src[i] = SRC_HOLD;
      if (w_issue && (CNT_W'(i) >= w_sel)) begin
        if (CNT_W'(i + 1) < r_count)                w_src[i] = SRC_SHIFT;
        else if (w_disp && (CNT_W'(i) == w_wslot))  w_src[i] = SRC_DISP;
        else                                        w_src[i] = SRC_CLEAR;
      end else if (w_disp && (CNT_W'(i) == w_wslot)) begin
        w_src[i] = SRC_DISP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_count <= '0;
    else        r_count <= r_count + CNT_W'(w_disp) - CNT_W'(w_issue);
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    equeue_int_entry #(
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W),
      .OP_W   (OP_W)
    ) u_entry (
      .clk            (clk),
      .i_rst_n        (reset),
      .i_src          (w_src[g]),
      .i_cdb_valid    (cdb_valid),
      .i_cdb_tag      (cdb_tag),
      .i_cdb_data     (cdb_data),
      .i_up_valid     (w_valid[g+1]),
      .i_up_opcode    (w_opcode[g+1]),
      .i_up_rsdata    (w_rsdata[g+1]),
      .i_up_rstag     (w_rstag[g+1]),
      .i_up_rsvalid   (w_rsvalid[g+1]),
      .i_up_rtdata    (w_rtdata[g+1]),
      .i_up_rttag     (w_rttag[g+1]),
      .i_up_rtvalid   (w_rtvalid[g+1]),
      .i_up_rdtag     (w_rdtag[g+1]),
      .i_disp_opcode  (dispatch_opcode),
      .i_disp_rsdata  (dispatch_rsdata),
      .i_disp_rstag   (dispatch_rstag),
      .i_disp_rsvalid (dispatch_rsvalid),
      .i_disp_rtdata  (dispatch_rtdata),
      .i_disp_rttag   (dispatch_rttag),
      .i_disp_rtvalid (dispatch_rtvalid),
      .i_disp_rdtag   (dispatch_rdtag),
      .o_valid        (w_valid[g]),
      .o_opcode       (w_opcode[g]),
      .o_rsdata       (w_rsdata[g]),
      .o_rstag        (w_rstag[g]),
      .o_rsvalid      (w_rsvalid[g]),
      .o_rtdata       (w_rtdata[g]),
      .o_rttag        (w_rttag[g]),
      .o_rtvalid      (w_rtvalid[g]),
      .o_rdtag        (w_rdtag[g]),
      .o_ready        (w_ready[g])
    );
  end

endmodule

// File: tb/tb_equeue_int.sv
module tb_equeue_int;

  logic        clk = 1'b0;
  logic        reset;
  logic        dispatch_en;
  logic [5:0]  dispatch_opcode;
  logic [31:0] dispatch_rsdata;
  logic [5:0]  dispatch_rstag;
  logic        dispatch_rsvalid;
  logic [31:0] dispatch_rtdata;
  logic [5:0]  dispatch_rttag;
  logic        dispatch_rtvalid;
  logic [5:0]  dispatch_rdtag;
  logic        equeue_full;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        issueint_ready;
  logic [5:0]  issueint_opcode;
  logic [31:0] issueint_rsdata;
  logic [31:0] issueint_rtdata;
  logic [5:0]  issueint_rdtag;
  logic        issueint_equeueint_done;

  int checks = 0;
  int errors = 0;

  equeue_int dut (
    .clk                     (clk),
    .reset                   (reset),
    .dispatch_en             (dispatch_en),
    .dispatch_opcode         (dispatch_opcode),
    .dispatch_rsdata         (dispatch_rsdata),
    .dispatch_rstag          (dispatch_rstag),
    .dispatch_rsvalid        (dispatch_rsvalid),
    .dispatch_rtdata         (dispatch_rtdata),
    .dispatch_rttag          (dispatch_rttag),
    .dispatch_rtvalid        (dispatch_rtvalid),
    .dispatch_rdtag          (dispatch_rdtag),
    .equeue_full             (equeue_full),
    .cdb_valid               (cdb_valid),
    .cdb_tag                 (cdb_tag),
    .cdb_data                (cdb_data),
    .issueint_ready          (issueint_ready),
    .issueint_opcode         (issueint_opcode),
    .issueint_rsdata         (issueint_rsdata),
    .issueint_rtdata         (issueint_rtdata),
    .issueint_rdtag          (issueint_rdtag),
    .issueint_equeueint_done (issueint_equeueint_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dispatch_en             = 1'b0;
    cdb_valid               = 1'b0;
    cdb_tag                 = '0;
    cdb_data                = '0;
    issueint_equeueint_done = 1'b0;
  endtask

  task automatic disp(input logic [5:0] op,
                      input logic [31:0] rsd, input logic [5:0] rst, input logic rsv,
                      input logic [31:0] rtd, input logic [5:0] rtt, input logic rtv,
                      input logic [5:0] rd);
    dispatch_en      = 1'b1;
    dispatch_opcode  = op;
    dispatch_rsdata  = rsd;
    dispatch_rstag   = rst;
    dispatch_rsvalid = rsv;
    dispatch_rtdata  = rtd;
    dispatch_rttag   = rtt;
    dispatch_rtvalid = rtv;
    dispatch_rdtag   = rd;
  endtask

  task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    disp(6'h0, 32'h0, 6'h0, 1'b0, 32'h0, 6'h0, 1'b0, 6'h0);
    dispatch_en = 1'b0;
    step();
    chk("rst_ready", issueint_ready, 0);
    chk("rst_full", equeue_full, 0);
    chk("rst_rdtag", issueint_rdtag, 0);
    chk("rst_rsdata", issueint_rsdata, 0);
    step();
    reset = 1'b1;
    step();

    // Fully-ready dispatch, issue, drain
    disp(6'h01, 32'd5, 6'd1, 1'b1, 32'd7, 6'd2, 1'b1, 6'd9);
    step(); idle();
    chk("t1_ready", issueint_ready, 1);
    chk("t1_op", issueint_opcode, 6'h01);
    chk("t1_rs", issueint_rsdata, 5);
    chk("t1_rt", issueint_rtdata, 7);
    chk("t1_rd", issueint_rdtag, 9);
    issueint_equeueint_done = 1'b1;
    step(); idle();
    chk("t1_empty", issueint_ready, 0);
    chk("t1_empty_rs", issueint_rsdata, 0);

    // rs waits on tag 12
    disp(6'h02, 32'h0, 6'd12, 1'b0, 32'd1, 6'd3, 1'b1, 6'd10);
    step(); idle();
    chk("t2_wait0", issueint_ready, 0);
    step();
    chk("t2_wait1", issueint_ready, 0);
    cdb(6'd12, 32'hDEAD);
    #1;
    chk("t2_no_same_cycle", issueint_ready, 0);
    step(); idle();
    chk("t2_woken", issueint_ready, 1);
    chk("t2_rs", issueint_rsdata, 32'hDEAD);
    chk("t2_rt", issueint_rtdata, 1);
    issueint_equeueint_done = 1'b1;
    step(); idle();
    chk("t2_empty", issueint_ready, 0);

    // Dispatch-cycle CDB bypass on rt
    disp(6'h03, 32'd2, 6'd4, 1'b1, 32'h0, 6'd20, 1'b0, 6'd11);
    cdb(6'd20, 32'd3);
    step(); idle();
    chk("t3_ready", issueint_ready, 1);
    chk("t3_rt", issueint_rtdata, 3);
    chk("t3_rs", issueint_rsdata, 2);
    issueint_equeueint_done = 1'b1;
    step(); idle();

    // Fill: slot0 waits 30, slot1 waits 31, slot2 ready, slot3 waits 33 on rt
    disp(6'h04, 32'h0, 6'd30, 1'b0, 32'h2, 6'd5, 1'b1, 6'd24); step();
    disp(6'h05, 32'h0, 6'd31, 1'b0, 32'h3, 6'd5, 1'b1, 6'd25); step();
    disp(6'h06, 32'hA, 6'd5, 1'b1, 32'hB, 6'd5, 1'b1, 6'd22); step();
    chk("t4_not_full3", equeue_full, 0);
    disp(6'h07, 32'h4, 6'd5, 1'b1, 32'h0, 6'd33, 1'b0, 6'd23); step(); idle();
    chk("t4_full", equeue_full, 1);
    chk("t4_sel_rd", issueint_rdtag, 22);
    chk("t4_sel_rs", issueint_rsdata, 32'hA);
    // Issue slot 2 while attempting a dispatch in the full cycle
    disp(6'h08, 32'h55, 6'd5, 1'b1, 32'h66, 6'd5, 1'b1, 6'd40);
    issueint_equeueint_done = 1'b1;
    step(); idle();
    chk("t4_full_fall", equeue_full, 0);
    chk("t4_drop", issueint_ready, 0);
    cdb(6'd33, 32'h77);
    step(); idle();
    chk("t4_shifted_rd", issueint_rdtag, 23);
    chk("t4_shifted_rt", issueint_rtdata, 32'h77);
    chk("t4_shifted_rs", issueint_rsdata, 32'h4);
    cdb(6'd30, 32'h100);
    step(); idle();
    chk("t4_older_rd", issueint_rdtag, 24);
    chk("t4_older_rs", issueint_rsdata, 32'h100);
    chk("t4_older_rt", issueint_rtdata, 32'h2);
    issueint_equeueint_done = 1'b1;
    step(); idle();
    chk("t4_next_rd", issueint_rdtag, 23);
    issueint_equeueint_done = 1'b1;
    step(); idle();
    chk("t4_left_wait", issueint_ready, 0);
    cdb(6'd31, 32'd5);
    step(); idle();
    chk("t4_last_rd", issueint_rdtag, 25);
    chk("t4_last_rs", issueint_rsdata, 5);
    issueint_equeueint_done = 1'b1;
    step(); idle();
    chk("t4_drained", issueint_ready, 0);
    chk("t4_drained_full", equeue_full, 0);

    // Capture while shifting down
    disp(6'h09, 32'd1, 6'd5, 1'b1, 32'd1, 6'd5, 1'b1, 6'd50); step();
    disp(6'h0A, 32'h0, 6'd41, 1'b0, 32'd2, 6'd5, 1'b1, 6'd51); step(); idle();
    chk("sh_first_rd", issueint_rdtag, 50);
    issueint_equeueint_done = 1'b1;
    cdb(6'd41, 32'hAB);
    step(); idle();
    chk("sh_ready", issueint_ready, 1);
    chk("sh_rd", issueint_rdtag, 51);
    chk("sh_rs", issueint_rsdata, 32'hAB);
    issueint_equeueint_done = 1'b1;
    step(); idle();

    // rs and rt both wait on tag 42
    disp(6'h0B, 32'h0, 6'd42, 1'b0, 32'h0, 6'd42, 1'b0, 6'd52);
    step(); idle();
    chk("both_wait", issueint_ready, 0);
    cdb(6'd42, 32'h99);
    step(); idle();
    chk("both_rs", issueint_rsdata, 32'h99);
    chk("both_rt", issueint_rtdata, 32'h99);
    issueint_equeueint_done = 1'b1;
    step(); idle();

    // Held done: stable presentation
    disp(6'h03, 32'h11, 6'd5, 1'b1, 32'h22, 6'd5, 1'b1, 6'd12);
    step(); idle();
    for (int k = 0; k < 3; k++) begin
      chk("hold_ready", issueint_ready, 1);
      chk("hold_rd", issueint_rdtag, 12);
      chk("hold_rs", issueint_rsdata, 32'h11);
      chk("hold_op", issueint_opcode, 6'h03);
      step();
    end
    issueint_equeueint_done = 1'b1;
    step(); idle();
    chk("hold_removed", issueint_ready, 0);

    // TAG_NULL never captures
    disp(6'h0C, 32'h0, 6'd0, 1'b0, 32'd7, 6'd5, 1'b1, 6'd53);
    step(); idle();
    cdb(6'd0, 32'd5);
    step(); idle();
    chk("null_nocap0", issueint_ready, 0);
    step();
    chk("null_nocap1", issueint_ready, 0);
    disp(6'h0D, 32'h31, 6'd5, 1'b1, 32'h32, 6'd5, 1'b1, 6'd54);
    step(); idle();
    chk("null_other_rd", issueint_rdtag, 54);

    // Asynchronous reset mid-cycle
    #2 reset = 1'b0;
    #1;
    chk("arst_ready", issueint_ready, 0);
    chk("arst_rd", issueint_rdtag, 0);
    chk("arst_rs", issueint_rsdata, 0);
    chk("arst_full", equeue_full, 0);
    step(); step();
    reset = 1'b1;
    step();
    chk("post_rst_ready", issueint_ready, 0);
    for (int k = 0; k < 3; k++) begin
      disp(6'h0E, 32'h0, 6'd60, 1'b0, 32'h0, 6'd61, 1'b0, 6'(k + 1));
      step(); idle();
      chk("refill_not_full", equeue_full, 0);
    end
    disp(6'h0E, 32'h0, 6'd60, 1'b0, 32'h0, 6'd61, 1'b0, 6'd4);
    step(); idle();
    chk("refill_full", equeue_full, 1);
    chk("refill_none_ready", issueint_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/equeue_int.md
Name: equeue_int

Overview:
Integer issue queue: the consumer end of the CDB and the producer end of the integer issue handshake.
- Accepts dispatched integer ops with partially-ready operands and snoops the CDB (cdb_valid/cdb_tag/cdb_data) to capture missing operands.
- Presents the oldest fully-ready entry on the issueint_* bus and retires it when issueint_equeueint_done is returned.
- Sits between dispatch and the issue/CDB unit.

Parameters:
DEPTH, 4, number of queue entries (2..8).
TAG_W, 6, physical tag width.
DATA_W, 32, operand data width.
OP_W, 6, opcode width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
dispatch_en  in  1  write one entry this cycle.
dispatch_opcode  in  OP_W  ALU opcode.
dispatch_rsdata  in  DATA_W  rs value, meaningful if dispatch_rsvalid.
dispatch_rstag  in  TAG_W  rs producer tag.
dispatch_rsvalid  in  1  rs value present.
dispatch_rtdata  in  DATA_W  rt value.
dispatch_rttag  in  TAG_W  rt producer tag.
dispatch_rtvalid  in  1  rt value present.
dispatch_rdtag  in  TAG_W  destination tag.
equeue_full  out  1  no free entry; dispatch_en ignored while high.
cdb_valid  in  1  CDB broadcast valid.
cdb_tag  in  TAG_W  CDB tag.
cdb_data  in  DATA_W  CDB data.
issueint_ready  out  1  a ready entry is presented.
issueint_opcode  out  OP_W  selected entry opcode.
issueint_rsdata  out  DATA_W  selected rs.
issueint_rtdata  out  DATA_W  selected rt.
issueint_rdtag  out  TAG_W  selected rd tag.
issueint_equeueint_done  in  1  issue unit accepted presented entry this cycle.

Behaviour:
Reset and storage:
- Reset (reset=0, async) clears all entry valid bits and count.
- Outputs during reset: equeue_full=0, issueint_ready=0, issueint_* data/tag/opcode=0.
- Entries are held oldest-first in slots 0..count-1 and shift-compacted.
- Per-entry state: valid, opcode, rs{data,tag,valid}, rt{data,tag,valid}, rdtag.

Ready and selection:
- Entry ready = valid & rsvalid & rtvalid, evaluated from registered state.
- A CDB capture makes the entry ready in the next cycle; there is no same-cycle wakeup-to-issue.
- Select is the lowest-index ready entry. issueint_* outputs are combinational from registered state.
- When no entry is ready: issueint_ready=0 and data outputs=0.

Issue handshake:
- issueint_equeueint_done with issueint_ready=1 removes the selected entry at the clock edge; entries above it shift down one slot.
- done with ready=0 is ignored.
- The issue unit may hold done low (CDB slot conflict). The entry then stays and is re-presented. Selection may change if an older entry became ready.

CDB snoop:
- On cdb_valid, every valid entry operand with valid=0 and tag==cdb_tag captures cdb_data and sets valid.
- Applies to shifting entries too: capture and shift occur in the same edge.
- TAG_NULL (0) never matches. The CDB carries tag 0 for stores.
- rs and rt of the same entry may both match and both capture.

Dispatch:
- Dispatch writes slot (count - removed_this_cycle).
- A dispatched operand with valid=0 whose tag matches a same-cycle CDB broadcast is written already captured (bypass).

Full condition:
- equeue_full = (count==DEPTH), registered-state based.
- A dispatch in a full cycle is dropped even if an issue frees a slot that cycle.
- Count is updated as count + (dispatch accepted) - (issued).

Branch/valid:
- CDB branch signals are not consumed.
- cdb_valid=0 cycles (including branch results) capture nothing.

Decomposition:
- Shared globals.vh gains: TAG_W, DATA_W, OP_W widths; TAG_NULL=0.
- One sub-module, equeue_entry: a single slot holding registers, CDB compare/capture, and a shift-in mux from slot i+1 or from dispatch. It outputs ready and its fields.
- The top level holds the count, priority select, and output mux.

Test Plan:
1. Dispatch op=ADD rs=5(valid) rt=7(valid) rd=9 → next cycle issueint_ready=1, rsdata=5, rtdata=7, rdtag=9; done=1 → following cycle ready=0, count=0.
2. Dispatch rs tag=12 not valid; two cycles later cdb_valid tag=12 data=0xDEAD → ready=0 that cycle, ready=1 next with rsdata=0xDEAD.
3. Dispatch with rttag=20 invalid in the same cycle as cdb tag=20 data=3 → entry ready next cycle with rtdata=3 (bypass).
4. Fill 4 entries, only slot 2 ready → slot 2 presented; done → slots 3 shifts to 2, count=3, equeue_full falls next cycle; dispatch during full cycle dropped.
5. Ready entry presented with done=0 for 3 cycles → outputs stable; done=1 in cycle 4 → removed.
6. cdb_valid tag=0 with an entry waiting on tag 0 → no capture; assert reset mid-operation → outputs 0 immediately, queue empty after release.
